priority_encoder_buf: RTL and testbench
=======================================

Name: priority_encoder_buf

Overview:
- Registered N-to-log2(N) priority encoder with a valid/ready handshake on both sides and a 2-entry output buffer.
- It is the encoding counterpart of the 2-to-4 decoder: it recovers a binary index from a one-hot (or multi-hot) vector.
- It sits between one-hot request sources and binary-index consumers.
- It flags zero and multi-hot inputs and counts multi-hot events.

Parameters:
- WIDTH, 4, input vector width; must be a power of 2 and at least 2.
- OUT_W, $clog2(WIDTH), output index width; derived, not overridden.
- CNT_W, 8, width of the multi-hot event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  val holds a transaction.
- in_ready  output  1  block can accept a transaction this cycle.
- val  input  WIDTH  vector to encode.
- out_valid  output  1  buffer head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- y  output  OUT_W  encoded index at the buffer head.
- zero  output  1  head came from val == 0.
- multi  output  1  head came from a vector with more than one bit set.
- multi_cnt  output  CNT_W  saturating count of accepted multi-hot vectors.

Behaviour:
- Reset, with the clock not required:
  - in_ready = 1, out_valid = 0, y = 0, zero = 0, multi = 0, multi_cnt = 0.
  - Buffer emptied.
  - An assertion mid-transfer discards all buffered entries immediately.
- Encoding:
  - y is the index of the highest set bit of val, so 4'b0110 -> 2 and 4'b0001 -> 0.
  - When val == 0: y = 0 and zero = 1.
  - multi = 1 when popcount(val) >= 2.
  - Encoding is combinational on val; the result is registered into the buffer.
- Accept: a transaction is accepted on a rising edge where in_valid && in_ready.
- Pop: an entry is removed on a rising edge where out_valid && out_ready.
- Buffer:
  - 2-entry FIFO holding {y, zero, multi}, tracked with a count of 0..2.
  - in_ready = (count < 2). It is a registered-state function only, with no combinational path from out_ready.
  - out_valid = (count > 0). y, zero and multi show the oldest entry.
  - While count == 0, y, zero and multi hold their last values; the bench must not check them.
- Latency: an entry accepted at edge k appears at the outputs with out_valid = 1 after edge k when the buffer was empty (1-cycle latency).
- Simultaneous accept and pop:
  - count is unchanged and ordering is preserved.
  - With count == 1, the new entry becomes the head after the pop.
  - With count == 2, no accept is possible because in_ready = 0.
- Stability: while out_valid && !out_ready, y, zero and multi must not change.
- Producer: may deassert in_valid at any time; val is ignored when no accept occurs.
- multi_cnt:
  - Increments on each accept with multi = 1, not on pop.
  - Saturates at 2^CNT_W - 1 and never wraps.
  - Cleared only by rst.
- State machine, by count:
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept with pop, or neither -> ONE.
  - FULL: pop -> ONE.

Test Plan:
- Reset, then drive val = 4'b0001, 4'b0010, 4'b0100, 4'b1000 with out_ready = 1 -> y = 0, 1, 2, 3, each 1 cycle after accept; zero = 0; multi = 0; multi_cnt = 0.
- val = 4'b0000 -> y = 0, zero = 1. Then val = 4'b1011 -> y = 3, multi = 1, multi_cnt = 1. Then val = 4'b0110 -> y = 2, multi_cnt = 2.
- Backpressure:
  - Hold out_ready = 0 and present 4'b0010 then 4'b1000. Both are accepted, then in_ready = 0. A third vector 4'b0100 held with in_valid = 1 is not accepted.
  - Release out_ready -> outputs y = 1, then 3, then 4 is not reachable (WIDTH=4), so 2 after the third is accepted. Order is preserved and y is stable while stalled.
- Simultaneous accept and pop: with count = 1 and both handshakes active for 10 consecutive cycles on values 4'b0001..4'b1000 cycling -> out_valid stays 1, in_ready stays 1, and the y sequence matches input order with no drops or duplicates.
- Saturation: with CNT_W = 2, accept 5 vectors of 4'b0011 -> multi_cnt = 1, 2, 3, 3, 3.
- Async reset mid-operation: with count = 2, pulse rst between clock edges -> out_valid = 0, in_ready = 1 and multi_cnt = 0 immediately. The first post-reset accept of 4'b0100 yields y = 2.

Source files
------------

// File: rtl/priority_encoder_buf.sv
// priority_encoder_buf: registered highest-set-bit encoder behind a 2-entry valid/ready buffer
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   producer handshake; val is the vector to encode
//   out_valid/out_ready consumer handshake on the buffer head
//   y, zero, multi      head entry: index of highest set bit, val==0 flag, multi-hot flag
//   multi_cnt           saturating count of accepted multi-hot vectors
module priority_encoder_buf #(
    parameter int WIDTH = 4,
    parameter int OUT_W = $clog2(WIDTH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y,
    output logic             zero,
    output logic             multi,
    output logic [CNT_W-1:0] multi_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_nx;
    logic [OUT_W-1:0] enc;
    logic [OUT_W+1:0] entry, slot0, slot1;
    logic push, pop;
    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++)
            if (val[i]) enc = OUT_W'(i);
    end
    // clearing the lowest set bit leaves something only when two or more bits were set
    assign entry = {enc, ~|val, |(val & (val - WIDTH'(1)))};
    assign in_ready = state != FULL;
    assign out_valid = state != EMPTY;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign y = slot0[OUT_W+1:2];
    assign zero = slot0[1];
    assign multi = slot0[0];
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   state_nx = push ? ONE : EMPTY;
            ONE:     state_nx = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
            FULL:    state_nx = pop ? ONE : FULL;
            default: state_nx = EMPTY;
        endcase
    end
    // slot0 is the head; a pop shifts slot1 forward, and a new entry lands in the
    // first slot that is free after that shift (later assignment wins over the shift)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
            multi_cnt <= '0;
        end else begin
            state <= state_nx;
            if (pop) slot0 <= slot1;
            if (push && (state == EMPTY || pop)) slot0 <= entry;
            if (push && state == ONE && !pop) slot1 <= entry;
            if (push && entry[0] && multi_cnt != '1) multi_cnt <= multi_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_priority_encoder_buf.sv
// tb_priority_encoder_buf: directed self-checking bench for priority_encoder_buf
module tb_priority_encoder_buf;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, zero, multi;
    logic [3:0] val = '0;
    logic [1:0] y;
    logic [1:0] multi_cnt;
    int checks = 0, errors = 0;

    priority_encoder_buf #(.WIDTH(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .val(val),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
        .multi(multi), .multi_cnt(multi_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // val, y, zero, multi, multi_cnt after accept
    int tv [7][5] = '{
        '{1, 0, 0, 0, 0}, '{2, 1, 0, 0, 0}, '{4, 2, 0, 0, 0}, '{8, 3, 0, 0, 0},
        '{0, 0, 1, 0, 0}, '{11, 3, 0, 1, 1}, '{6, 2, 0, 1, 2}
    };

    initial begin
        #3;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_y", 32'(y), 0);
        check("rst_zero", 32'(zero), 0);
        check("rst_multi", 32'(multi), 0);
        check("rst_cnt", 32'(multi_cnt), 0);
        @(negedge clk);
        rst = 0;
        out_ready = 1;
        for (int i = 0; i < 7; i++) begin
            val = 4'(tv[i][0]);
            in_valid = 1;
            @(negedge clk);
            in_valid = 0;
            check("enc_valid", 32'(out_valid), 1);
            check("enc_y", 32'(y), tv[i][1]);
            check("enc_zero", 32'(zero), tv[i][2]);
            check("enc_multi", 32'(multi), tv[i][3]);
            check("enc_cnt", 32'(multi_cnt), tv[i][4]);
            @(negedge clk);
            check("enc_drain", 32'(out_valid), 0);
        end
        // backpressure
        out_ready = 0;
        val = 4'b0010;
        in_valid = 1;
        @(negedge clk);
        check("bp_y1", 32'(y), 1);
        check("bp_ready1", 32'(in_ready), 1);
        val = 4'b1000;
        @(negedge clk);
        check("bp_full", 32'(in_ready), 0);
        check("bp_hold", 32'(y), 1);
        val = 4'b0100;
        @(negedge clk);
        check("bp_blocked", 32'(in_ready), 0);
        check("bp_stable", 32'(y), 1);
        @(negedge clk);
        check("bp_stable2", 32'(y), 1);
        out_ready = 1;
        @(negedge clk);
        check("bp_y2", 32'(y), 3);
        check("bp_ready2", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 0;
        check("bp_y3", 32'(y), 2);
        check("bp_valid3", 32'(out_valid), 1);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 0);
        check("bp_cnt", 32'(multi_cnt), 2);
        // simultaneous accept and pop at count 1
        val = 4'b0001;
        in_valid = 1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("sim_valid", 32'(out_valid), 1);
            check("sim_ready", 32'(in_ready), 1);
            check("sim_y", 32'(y), i % 4);
            val = 4'(1 << ((i + 1) % 4));
            @(negedge clk);
        end
        check("sim_last", 32'(y), 2);
        in_valid = 0;
        @(negedge clk);
        check("sim_empty", 32'(out_valid), 0);
        // fill to two multi-hot entries, then async reset between edges
        out_ready = 0;
        val = 4'b1011;
        in_valid = 1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 0;
        check("pre_full", 32'(in_ready), 0);
        check("pre_cnt_sat", 32'(multi_cnt), 3);
        #2 rst = 1;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_ready", 32'(in_ready), 1);
        check("arst_cnt", 32'(multi_cnt), 0);
        #1 rst = 0;
        @(negedge clk);
        out_ready = 1;
        val = 4'b0100;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        check("post_valid", 32'(out_valid), 1);
        check("post_y", 32'(y), 2);
        @(negedge clk);
        // saturation of the 2-bit counter
        val = 4'b0011;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sat_cnt", 32'(multi_cnt), i < 3 ? i + 1 : 3);
            check("sat_y", 32'(y), 1);
            check("sat_multi", 32'(multi), 1);
        end
        in_valid = 0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
